decode_queue: RTL and testbench

Parametrised decode stage with an elastic buffer, sitting between fetch and issue.
- Accepts raw 32-bit RISC-V instructions with their PC over a valid/ready handshake.
- Decodes each instruction into register, function and immediate fields, and sign-extends the immediate to XLEN.
- Buffers up to DEPTH decoded entries so that fetch is decoupled from issue stalls.
- Adds over the previous decoder: RV64 opcode mode, an explicit illegal flag instead of silently zeroed fields, flush, and back-pressure.

---
 rtl/decode_queue_if.sv | 39 +++
 rtl/decode_queue.sv | 175 +++++++++++++++++
 tb/tb_decode_queue.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// Fetch-to-issue handshake bundle for the decode queue.
// The queue itself connects through the slave modport.
interface decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  logic [CW-1:0]   count;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal, count
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal, count
  );
endinterface

// File: rtl/decode_queue.sv
// RISC-V decode stage followed by a DEPTH-entry circular buffer that decouples
// fetch from issue; undecodable words travel through flagged as illegal.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset_n,
  decode_queue_if.slave dq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] FMT_BAD = 3'd0;
  localparam logic [2:0] FMT_R   = 3'd1;
  localparam logic [2:0] FMT_I   = 3'd2;
  localparam logic [2:0] FMT_S   = 3'd3;
  localparam logic [2:0] FMT_B   = 3'd4;
  localparam logic [2:0] FMT_U   = 3'd5;
  localparam logic [2:0] FMT_J   = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  logic [31:0]   inst;
  logic [2:0]    fmt;
  entry_t        dec;
  entry_t        mem [DEPTH];
  entry_t        head_entry;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          in_ready_q;
  logic          out_valid;
  logic          enq;
  logic          deq;

  assign inst = dq.in_inst;

  // The RV64-only word opcodes fall through to illegal on a 32-bit datapath.
  always_comb begin
    fmt = FMT_BAD;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: fmt = FMT_I;
        7'h17, 7'h37:                      fmt = FMT_U;
        7'h23:                             fmt = FMT_S;
        7'h33:                             fmt = FMT_R;
        7'h63:                             fmt = FMT_B;
        7'h6F:                             fmt = FMT_J;
        7'h1B:                             fmt = (XLEN == 64) ? FMT_I : FMT_BAD;
        7'h3B:                             fmt = (XLEN == 64) ? FMT_R : FMT_BAD;
        default:                           fmt = FMT_BAD;
      endcase
    end
  end

  always_comb begin
    dec         = '0;
    dec.pc      = dq.in_pc;
    dec.opcode  = inst[6:0];
    dec.illegal = (fmt == FMT_BAD);
    case (fmt)
      FMT_R: begin
        dec.rd     = inst[11:7];
        dec.funct3 = inst[14:12];
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.funct7 = inst[31:25];
      end
      FMT_I: begin
        dec.rd     = inst[11:7];
        dec.funct3 = inst[14:12];
        dec.rs1    = inst[19:15];
        dec.imm    = XLEN'($signed(inst[31:20]));
      end
      FMT_S: begin
        dec.funct3 = inst[14:12];
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.imm    = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      FMT_B: begin
        dec.funct3 = inst[14:12];
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.imm    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      FMT_U: begin
        dec.rd     = inst[11:7];
        dec.imm    = XLEN'($signed({inst[31:12], 12'b0}));
      end
      FMT_J: begin
        dec.rd     = inst[11:7];
        dec.imm    = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      default: ;
    endcase
  end

  // in_ready is a register, so a full queue refuses input even while draining.
  assign out_valid = (count_q != '0);
  assign enq       = dq.in_valid && in_ready_q;
  assign deq       = out_valid && dq.out_ready;

  always_comb begin
    count_nxt = count_q;
    if (enq && !deq) begin
      count_nxt = count_q + 1'b1;
    end else if (!enq && deq) begin
      count_nxt = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else if (dq.flush) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      count_q    <= count_nxt;
      in_ready_q <= (count_nxt != FULL);
    end
  end

  // Clearing every slot on reset makes the head fields read zero while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enq && !dq.flush) begin
      mem[tail] <= dec;
    end
  end

  assign head_entry     = mem[head];
  assign dq.in_ready    = in_ready_q;
  assign dq.out_valid   = out_valid;
  assign dq.count       = count_q;
  assign dq.out_pc      = head_entry.pc;
  assign dq.out_opcode  = head_entry.opcode;
  assign dq.out_rd      = head_entry.rd;
  assign dq.out_rs1     = head_entry.rs1;
  assign dq.out_rs2     = head_entry.rs2;
  assign dq.out_funct3  = head_entry.funct3;
  assign dq.out_funct7  = head_entry.funct7;
  assign dq.out_imm     = head_entry.imm;
  assign dq.out_illegal = head_entry.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: one XLEN=32 and one XLEN=64 instance are
// driven from the same stimulus and checked against hand-computed values.
module tb_decode_queue;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        flush     = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst   = '0;
  logic [63:0] in_pc     = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_queue_if #(.XLEN(32), .DEPTH(4)) q32 ();
  decode_queue_if #(.XLEN(64), .DEPTH(4)) q64 ();

  assign q32.in_valid  = in_valid;
  assign q32.in_inst   = in_inst;
  assign q32.in_pc     = in_pc[31:0];
  assign q32.flush     = flush;
  assign q32.out_ready = out_ready;

  assign q64.in_valid  = in_valid;
  assign q64.in_inst   = in_inst;
  assign q64.in_pc     = in_pc;
  assign q64.flush     = flush;
  assign q64.out_ready = out_ready;

  decode_queue #(.XLEN(32), .DEPTH(4)) dut32 (.clk(clk), .reset_n(reset_n), .dq(q32));
  decode_queue #(.XLEN(64), .DEPTH(4)) dut64 (.clk(clk), .reset_n(reset_n), .dq(q64));

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    stepClock();
    in_valid = 1'b0;
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    stepClock();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("reset count", q32.count, 0);
    checkOutput("reset out_valid", q32.out_valid, 0);
    checkOutput("reset in_ready", q32.in_ready, 0);
    checkOutput("reset out_imm", q64.out_imm, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stepClock();
    checkOutput("in_ready after release", q32.in_ready, 1);

    // addi x1,x2,-1
    applyStimulus(32'hFFF10093, 64'h100);
    checkOutput("addi out_valid", q32.out_valid, 1);
    checkOutput("addi opcode", q32.out_opcode, 7'h13);
    checkOutput("addi rd", q32.out_rd, 1);
    checkOutput("addi rs1", q32.out_rs1, 2);
    checkOutput("addi funct3", q32.out_funct3, 0);
    checkOutput("addi imm32", q32.out_imm, 64'hFFFF_FFFF);
    checkOutput("addi imm64", q64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi illegal", q32.out_illegal, 0);
    checkOutput("addi pc", q32.out_pc, 64'h100);
    checkOutput("addi count", q32.count, 1);
    popOne();
    checkOutput("empty after pop", q32.out_valid, 0);

    // beq x0,x0,-4
    applyStimulus(32'hFE000EE3, 64'h104);
    checkOutput("beq imm32", q32.out_imm, 64'hFFFF_FFFC);
    checkOutput("beq imm64", q64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("beq rd", q32.out_rd, 0);
    checkOutput("beq rs1", q32.out_rs1, 0);
    checkOutput("beq rs2", q32.out_rs2, 0);
    checkOutput("beq funct3", q32.out_funct3, 0);
    checkOutput("beq opcode", q32.out_opcode, 7'h63);
    popOne();

    // lui x1,0x80000
    applyStimulus(32'h800000B7, 64'h108);
    checkOutput("lui imm64", q64.out_imm, 64'hFFFF_FFFF_8000_0000);
    checkOutput("lui imm32", q32.out_imm, 64'h8000_0000);
    checkOutput("lui rd", q64.out_rd, 1);
    checkOutput("lui rs1", q64.out_rs1, 0);
    popOne();

    // all-zero word
    applyStimulus(32'h00000000, 64'h10C);
    checkOutput("zero illegal", q32.out_illegal, 1);
    checkOutput("zero imm", q32.out_imm, 0);
    checkOutput("zero rd", q32.out_rd, 0);
    checkOutput("zero pc", q32.out_pc, 64'h10C);
    popOne();

    // addiw x1,x1,1
    applyStimulus(32'h0010809B, 64'h110);
    checkOutput("addiw32 illegal", q32.out_illegal, 1);
    checkOutput("addiw32 rd", q32.out_rd, 0);
    checkOutput("addiw32 imm", q32.out_imm, 0);
    checkOutput("addiw32 opcode", q32.out_opcode, 7'h1B);
    checkOutput("addiw64 illegal", q64.out_illegal, 0);
    checkOutput("addiw64 imm", q64.out_imm, 1);
    checkOutput("addiw64 rd", q64.out_rd, 1);
    checkOutput("addiw64 rs1", q64.out_rs1, 1);
    popOne();

    // three fill/drain passes so head and tail both wrap
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(32'(32'h13 | ((i + 1) << 7)), 64'(i * 4));
      end
      checkOutput("fill count", q32.count, 4);
      checkOutput("fill in_ready", q32.in_ready, 0);
      in_valid = 1'b1;
      in_inst  = 32'h00500293;
      in_pc    = 64'hDEAD;
      stepClock();
      checkOutput("full holds count", q32.count, 4);
      checkOutput("full head stable", q32.out_pc, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        checkOutput("drain pc", q32.out_pc, 64'(i * 4));
        checkOutput("drain rd", q64.out_rd, 64'(i + 1));
        stepClock();
      end
      out_ready = 1'b0;
      checkOutput("drained out_valid", q32.out_valid, 0);
      checkOutput("drained count", q64.count, 0);
    end

    // simultaneous enqueue and dequeue at count=2
    applyStimulus(32'h00100093, 64'h200);
    applyStimulus(32'h00100093, 64'h204);
    checkOutput("pair count", q32.count, 2);
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b1;
      in_pc     = 64'(32'h208 + 4 * k);
      out_ready = 1'b1;
      checkOutput("stream head pc", q32.out_pc, 64'(32'h200 + 4 * k));
      stepClock();
      checkOutput("stream count", q32.count, 2);
    end

    // flush with a concurrent enqueue
    in_valid  = 1'b1;
    in_pc     = 64'h300;
    out_ready = 1'b0;
    flush     = 1'b1;
    stepClock();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush count", q32.count, 0);
    checkOutput("flush out_valid", q32.out_valid, 0);
    checkOutput("flush in_ready", q32.in_ready, 1);
    stepClock();
    checkOutput("flushed entry absent", q32.out_valid, 0);
    applyStimulus(32'h00100093, 64'h400);
    checkOutput("post-flush pc", q32.out_pc, 64'h400);
    checkOutput("post-flush count", q32.count, 1);
    popOne();

    // asynchronous reset with three entries queued
    applyStimulus(32'h00100093, 64'h500);
    applyStimulus(32'h00200113, 64'h504);
    applyStimulus(32'h00300193, 64'h508);
    checkOutput("pre-reset count", q32.count, 3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", q32.out_valid, 0);
    checkOutput("async reset count", q32.count, 0);
    checkOutput("async reset in_ready", q32.in_ready, 0);
    checkOutput("async reset out_pc", q32.out_pc, 0);
    checkOutput("async reset out_rd", q64.out_rd, 0);
    stepClock();
    checkOutput("held reset in_ready", q32.in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stepClock();
    checkOutput("release in_ready", q32.in_ready, 1);
    checkOutput("release count", q32.count, 0);
    applyStimulus(32'hFFF10093, 64'h600);
    checkOutput("post-reset out_valid", q32.out_valid, 1);
    checkOutput("post-reset rd", q32.out_rd, 1);
    checkOutput("post-reset rs1", q32.out_rs1, 2);
    checkOutput("post-reset imm", q32.out_imm, 64'hFFFF_FFFF);
    checkOutput("post-reset pc", q32.out_pc, 64'h600);
    checkOutput("post-reset count", q32.count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
